// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU-side arithmetic blocks.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

  localparam int MUL_W = 4;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-and-add iteration: conditional add, then shift operands.
module mul_step #(
  parameter int W = 4
) (
  input  logic [2*W-1:0] acc,
  input  logic [2*W-1:0] mcand,
  input  logic [W-1:0]   mplier,
  output logic [2*W-1:0] acc_next,
  output logic [2*W-1:0] mcand_next,
  output logic [W-1:0]   mplier_next
);

  assign acc_next    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_next  = {mcand[2*W-2:0], 1'b0};
  assign mplier_next = {1'b0, mplier[W-1:1]};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential W x W -> 2W unsigned multiplier with valid/ready handshakes on both sides.
module shift_add_multiplier
  import alu_pkg::*;
#(
  parameter int W = MUL_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int CW = $clog2(W) + 1;

  mul_state_t      state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   count_q, count_d;

  logic [2*W-1:0]  step_acc;
  logic [2*W-1:0]  step_mcand;
  logic [W-1:0]    step_mplier;

  mul_step #(.W(W)) u_step (
    .acc         (acc_q),
    .mcand       (mcand_q),
    .mplier      (mplier_q),
    .acc_next    (step_acc),
    .mcand_next  (step_mcand),
    .mplier_next (step_mplier)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = {{W{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      // Always W iterations, even once the multiplier has shifted down to zero.
      RUN: begin
        acc_d    = step_acc;
        mcand_d  = step_mcand;
        mplier_d = step_mplier;
        count_d  = count_q + 1'b1;
        if (count_q == CW'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign product   = acc_q;

  a_no_dual_handshake : assert property (@(posedge clk) disable iff (rst)
    !(out_valid && in_ready));

  a_product_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> $stable(product));

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized self-checking bench for shift_add_multiplier against an a*b reference.
module tb_shift_add_multiplier;

  localparam int W = 4;
  localparam int MAX_WAIT = 40;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int tests;
  int fails;

  shift_add_multiplier #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the product is plain unsigned multiplication widened to 2W bits.
  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned r;
    r = int'(x) * int'(y);
    return r[2*W-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
      fails++;
      $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 00",
               in_ready, out_valid, busy, product);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] pa[$];
    logic [W-1:0] pb[$];
    logic [2*W-1:0] exp;
    int cycles;
    pa = '{4'd3, 4'hF, 4'hF, 4'h0, 4'h1};
    pb = '{4'd5, 4'hF, 4'h0, 4'h0, 4'hF};
    for (int i = 0; i < 6; i++) begin
      pa.push_back(W'($urandom));
      pb.push_back(W'($urandom));
    end
    out_ready = 1'b1;
    for (int i = 0; i < pa.size(); i++) begin
      exp = ref_product(pa[i], pb[i]);
      a = pa[i];
      b = pb[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < MAX_WAIT) begin
        @(posedge clk); #1;
        cycles++;
      end
      tests++;
      if (cycles != W) begin
        fails++;
        $display("[TB] FAIL basic_latency a=%h b=%h: got %0d cycles, want %0d", pa[i], pb[i], cycles, W);
      end
      tests++;
      if (product !== exp || busy !== 1'b1) begin
        fails++;
        $display("[TB] FAIL basic_product a=%h b=%h: got %h busy=%b, want %h busy=1",
                 pa[i], pb[i], product, busy, exp);
      end
      @(posedge clk); #1;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL basic_return a=%h b=%h: in_ready=%b out_valid=%b, want 1 0",
                 pa[i], pb[i], in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int cycles;
    out_ready = 1'b0;
    a = 4'd9;
    b = 4'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < MAX_WAIT) begin
      @(posedge clk); #1;
      cycles++;
    end
    tests++;
    if (cycles != W) begin
      fails++;
      $display("[TB] FAIL bp_latency: got %0d cycles, want %0d", cycles, W);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || product !== 8'h3F || in_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL bp_hold cycle %0d: out_valid=%b product=%h in_ready=%b, want 1 3f 0",
                 i, out_valid, product, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignored_input();
    int cycles;
    logic saw_ready;
    out_ready = 1'b1;
    a = 4'd2;
    b = 4'd6;
    in_valid = 1'b1;
    @(posedge clk); #1;
    a = 4'hF;
    b = 4'hF;
    cycles = 0;
    saw_ready = 1'b0;
    while (out_valid !== 1'b1 && cycles < MAX_WAIT) begin
      if (in_ready !== 1'b0) saw_ready = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    tests++;
    if (product !== 8'h0C || cycles != W || saw_ready) begin
      fails++;
      $display("[TB] FAIL ignore_first: product=%h cycles=%0d in_ready_seen=%b, want 0c %0d 0",
               product, cycles, saw_ready, W);
    end
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ignore_idle: in_ready=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < MAX_WAIT) begin
      @(posedge clk); #1;
      cycles++;
    end
    tests++;
    if (product !== 8'hE1 || cycles != W) begin
      fails++;
      $display("[TB] FAIL ignore_second: product=%h cycles=%0d, want e1 %0d", product, cycles, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    int cycles;
    out_ready = 1'b1;
    a = 4'd5;
    b = 4'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || product !== '0) begin
      fails++;
      $display("[TB] FAIL midop_reset: out_valid=%b in_ready=%b busy=%b product=%h, want 0 1 0 00",
               out_valid, in_ready, busy, product);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    a = 4'd1;
    b = 4'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < MAX_WAIT) begin
      @(posedge clk); #1;
      cycles++;
    end
    tests++;
    if (product !== 8'h01 || cycles != W) begin
      fails++;
      $display("[TB] FAIL midop_after: product=%h cycles=%0d, want 01 %0d", product, cycles, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] exp;
    int next_idx;
    int recv;
    int cyc;
    next_idx = 0;
    recv = 0;
    cyc = 0;
    while (recv < 256 && cyc < 20000) begin
      if (next_idx < 256) begin
        in_valid = 1'b1;
        a = next_idx[7:4];
        b = next_idx[3:0];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_product(a, b));
        next_idx++;
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL b2b_extra: got product %h with nothing outstanding", product);
        end else begin
          exp = exp_q.pop_front();
          if (product !== exp) begin
            fails++;
            $display("[TB] FAIL b2b_product #%0d: got %h, want %h", recv, product, exp);
          end
        end
        recv++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (recv != 256 || next_idx != 256 || exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL b2b_count: received %0d accepted %0d pending %0d, want 256 256 0",
               recv, next_idx, exp_q.size());
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_input();
    test_reset_midop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
